// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared digit count, saturation limit and FSM encodings for the BCD converter
//  DIGITS  number of BCD digits driven to the display
//  MAX_VAL largest value representable in DIGITS decimal digits
//  state_t converter FSM states; encoding 2'd3 is unused and recovers to IDLE
package bin_to_bcd_seq_pkg;
    localparam int DIGITS = 4;
    localparam int MAX_VAL = 9999;
    typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bin_to_bcd_seq_adjust.sv
// bin_to_bcd_seq_adjust: per-digit add-3 correction applied before each double-dabble shift
//  d_i  4-bit scratch digit
//  d_o  d_i + 3 when d_i >= 5, else d_i (no carry out of the digit)
module bin_to_bcd_seq_adjust (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);
    assign d_o = d_i >= 4'd5 ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with valid/ready input and held outputs
//  Clk        system clock
//  Reset      asynchronous active-high reset
//  In_Value   unsigned binary input, saturated to MAX_VAL at accept
//  In_Valid   In_Value valid; transfers only when In_Ready is high
//  In_Ready   converter idle and able to accept
//  BCD3..BCD0 thousands..units digits, updated only when Out_Valid pulses
//  Out_Valid  one-cycle pulse when new digits are loaded
//  Overflow   last accepted value exceeded MAX_VAL
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_WIDTH = 14
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [IN_WIDTH-1:0] In_Value,
    input  logic                In_Valid,
    output logic                In_Ready,
    output logic [3:0]          BCD3,
    output logic [3:0]          BCD2,
    output logic [3:0]          BCD1,
    output logic [3:0]          BCD0,
    output logic                Out_Valid,
    output logic                Overflow
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);
    state_t              state_q;
    logic [IN_WIDTH-1:0] op_q, op_d;
    logic [SW-1:0]       scr_q, scr_d, adj, bcd_q;
    logic [CW-1:0]       cnt_q;
    logic                out_valid_q, ovf_q, sat_q, sat;
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bin_to_bcd_seq_adjust u_adj (.d_i(scr_q[4*i +: 4]), .d_o(adj[4*i +: 4]));
    end
    // Adjusted scratch and operand shift together as one register.
    assign {scr_d, op_d} = {adj, op_q} << 1;
    assign sat = In_Value > IN_WIDTH'(MAX_VAL);
    assign In_Ready = state_q == IDLE;
    assign {BCD3, BCD2, BCD1, BCD0} = bcd_q;
    assign Out_Valid = out_valid_q;
    assign Overflow = ovf_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            scr_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (In_Valid) begin
                    op_q    <= sat ? IN_WIDTH'(MAX_VAL) : In_Value;
                    sat_q   <= sat;
                    scr_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= CONVERT;
                end
                CONVERT: begin
                    op_q    <= op_d;
                    scr_q   <= scr_d;
                    cnt_q   <= cnt_q + CW'(1);
                    state_q <= cnt_q == CW'(IN_WIDTH - 1) ? DONE : CONVERT;
                end
                DONE: begin
                    bcd_q       <= scr_q;
                    ovf_q       <= sat_q;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for the sequential binary-to-BCD converter
module tb_bin_to_bcd_seq;
    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [13:0] In_Value = '0;
    logic        In_Valid = 1'b0;
    logic        In_Ready, Out_Valid, Overflow;
    logic [3:0]  BCD3, BCD2, BCD1, BCD0;
    int          checks = 0, errors = 0, cyc = 0, acc_a, acc_b;
    exp_t        sb[$];
    logic [15:0] prev = '0;

    bin_to_bcd_seq dut (
        .Clk(Clk), .Reset(Reset), .In_Value(In_Value), .In_Valid(In_Valid),
        .In_Ready(In_Ready), .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
        .Out_Valid(Out_Valid), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int v, input int acc);
        exp_t e;
        int s;
        s = v > 9999 ? 9999 : v;
        e.bcd = {4'(s / 1000), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
        e.ovf = v > 9999;
        e.acc = acc;
        return e;
    endfunction

    always @(negedge Clk) begin
        if (!Reset) begin
            if (Out_Valid) begin
                if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bcd", {BCD3, BCD2, BCD1, BCD0}, e.bcd);
                    chk("ovf", Overflow, e.ovf);
                    chk("latency", cyc - e.acc, 15);
                end
            end else if ({BCD3, BCD2, BCD1, BCD0} !== prev) chk("stable", {BCD3, BCD2, BCD1, BCD0}, prev);
        end
        prev = {BCD3, BCD2, BCD1, BCD0};
    end

    task automatic send(input int v, output int acc);
        bit done = 0;
        acc = -1;
        In_Value = 14'(v);
        In_Valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge Clk);
            if (In_Ready) begin
                @(posedge Clk);
                #1;
                acc = cyc;
                sb.push_back(model(v, acc));
                done = 1;
            end else begin
                @(posedge Clk);
                #1;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
        In_Valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge Clk);
        chk("drain", sb.size(), 0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_bcd", {BCD3, BCD2, BCD1, BCD0}, 0);
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_ready", In_Ready, 1);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        send(1234, acc_a);
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            chk("ready_low", In_Ready, 0);
        end
        @(negedge Clk);
        chk("ready_back", In_Ready, 1);
        drain();
        send(0, acc_a);
        send(9999, acc_b);
        chk("b2b_accept_gap", acc_b - acc_a, 16);
        drain();
        send(12000, acc_a);
        send(7, acc_b);
        drain();
        send(16383, acc_a);
        send(10000, acc_b);
        drain();
        send(1000, acc_a);
        repeat (4) @(posedge Clk);
        #1;
        In_Value = 14'd4321;
        In_Valid = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        drain();
        repeat (20) @(posedge Clk);
        #1;
        chk("after_ignored", {BCD3, BCD2, BCD1, BCD0}, 16'h1000);
        send(5678, acc_a);
        repeat (7) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_bcd", {BCD3, BCD2, BCD1, BCD0}, 0);
        chk("async_out_valid", Out_Valid, 0);
        chk("async_ready", In_Ready, 1);
        sb.delete();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        chk("no_pulse_after_abort", {BCD3, BCD2, BCD1, BCD0}, 0);
        for (int v = 0; v <= 9999; v += 173) begin
            send(v, acc_a);
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            #1;
        end
        for (int k = 0; k < 20; k++) begin
            send(int'($urandom_range(0, 9999)), acc_a);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end
        send(9999, acc_a);
        send(1, acc_a);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
